// File: rtl/mmio_tx_fifo_if.sv
// rtl/mmio_tx_fifo_if.sv - store-bus snoop, status read and TX drain stream bundle
interface mmio_tx_fifo_if;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        stat_sel;
   logic [31:0] stat_rd;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        overflow;

   modport slave (
      input  memwrite, dataadr, writedata, out_ready,
      output stat_sel, stat_rd, out_valid, out_data, overflow
   );

   modport master (
      output memwrite, dataadr, writedata, out_ready,
      input  stat_sel, stat_rd, out_valid, out_data, overflow
   );
endinterface

// File: rtl/mmio_tx_fifo.sv
// rtl/mmio_tx_fifo.sv - MMIO TX FIFO snooping processor stores; MMIO_DROP_CNT_EN adds a drop counter
module mmio_tx_fifo #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] TX_ADDR   = 32'h0000_FFF0,
   parameter logic [31:0] STAT_ADDR = 32'h0000_FFF4
) (
   input logic            clk,
   input logic            reset,
   mmio_tx_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   mem_q [DEPTH];

   logic push, pop, push_acc, drop, stat_clr, empty, full;
   logic [15:0] drop_hi;

   always_comb begin
      push     = bus.memwrite && (bus.dataadr == TX_ADDR);
      stat_clr = bus.memwrite && (bus.dataadr == STAT_ADDR);
      empty    = (count_q == '0);
      full     = (count_q == (AW+1)'(DEPTH));
      pop      = !empty && bus.out_ready;
      // When full, a push only fits if the head leaves in the same cycle.
      push_acc = push && (!full || pop);
      drop     = push && full && !pop;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_acc, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      if (stat_clr) overflow_d = 1'b0;
      if (drop)     overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= bus.writedata;
   end

`ifdef MMIO_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = stat_clr ? 16'h0 : drop_cnt_q;
      if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'h1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_cnt_q <= 16'h0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_hi = drop_cnt_q;
`else
   assign drop_hi = 16'h0;
`endif

   // RAM is not reset, so the head is masked to zero whenever nothing is queued.
   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? 32'h0 : mem_q[rd_ptr_q];
   assign bus.overflow  = overflow_q;
   assign bus.stat_sel  = (bus.dataadr == STAT_ADDR);
   assign bus.stat_rd   = {drop_hi, 8'(count_q), 5'b0, overflow_q, full, empty};
endmodule

// File: tb/tb_mmio_tx_fifo.sv
// tb/tb_mmio_tx_fifo.sv - scoreboard bench for mmio_tx_fifo
module tb_mmio_tx_fifo;
   localparam logic [31:0] TX   = 32'h0000_FFF0;
   localparam logic [31:0] STAT = 32'h0000_FFF4;
   localparam int          DEP  = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   mmio_tx_fifo_if bus ();

   mmio_tx_fifo #(.DEPTH(DEP), .TX_ADDR(TX), .STAT_ADDR(STAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int          tot = 0;
   int          bad = 0;
   logic [31:0] sb[$];
   bit          ovf_m = 1'b0;
   int          drop_m = 0;
   logic [31:0] last_out = 32'h0;

   function automatic logic [31:0] exp_stat();
      logic [15:0] hi;
`ifdef MMIO_DROP_CNT_EN
      hi = drop_m[15:0];
`else
      hi = 16'h0;
`endif
      return {hi, 8'(sb.size()), 5'b0, ovf_m, (sb.size() == DEP), (sb.size() == 0)};
   endfunction

   // Model the cycle at negedge (inputs stable), then advance past the next edge.
   task automatic cycle();
      logic        p, s, q, f;
      logic [31:0] e;
      @(negedge clk);
      p = bus.memwrite && (bus.dataadr == TX);
      s = bus.memwrite && (bus.dataadr == STAT);
      f = (sb.size() == DEP);
      tot++;
      if (bus.out_valid !== (sb.size() != 0)) begin
         bad++;
         $display("FAIL out_valid got=%b exp=%b", bus.out_valid, (sb.size() != 0));
      end
      q = bus.out_valid && bus.out_ready;
      if (q) begin
         tot++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow got=%h exp=<none>", bus.out_data);
         end else begin
            e = sb.pop_front();
            last_out = bus.out_data;
            if (bus.out_data !== e) begin
               bad++;
               $display("FAIL out_data got=%h exp=%h", bus.out_data, e);
            end
         end
      end
      if (s) begin
         ovf_m = 1'b0;
         drop_m = 0;
      end
      if (p) begin
         if (!f || q) sb.push_back(bus.writedata);
         else begin
            ovf_m = 1'b1;
            if (drop_m < 16'hFFFF) drop_m++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.memwrite = 1'b1;
      bus.dataadr = a;
      bus.writedata = d;
      cycle();
      bus.memwrite = 1'b0;
      bus.dataadr = 32'h0;
   endtask

   task automatic drain(input int n);
      bus.out_ready = 1'b1;
      repeat (n) cycle();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tot++;
      if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b%b exp=00", bus.out_valid, bus.overflow);
      end
      tot++;
      if (bus.stat_rd !== 32'h0000_0001) begin
         bad++;
         $display("FAIL reset_stat got=%h exp=%h", bus.stat_rd, 32'h1);
      end
      tot++;
      if (bus.out_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_data got=%h exp=0", bus.out_data);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      store(TX, 32'hA5);
      tot++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5) begin
         bad++;
         $display("FAIL single_head got=%b/%h exp=1/000000a5", bus.out_valid, bus.out_data);
      end
      tot++;
      if (bus.stat_rd !== 32'h0000_0100) begin
         bad++;
         $display("FAIL single_stat got=%h exp=%h", bus.stat_rd, 32'h100);
      end
      drain(1);
      tot++;
      if (bus.stat_rd !== 32'h0000_0001) begin
         bad++;
         $display("FAIL single_empty got=%h exp=%h", bus.stat_rd, 32'h1);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEP + 1; i++) store(TX, 32'(i));
      tot++;
      if (bus.stat_rd[15:0] !== 16'h0806 || bus.stat_rd !== exp_stat()) begin
         bad++;
         $display("FAIL ovf_stat got=%h exp=%h", bus.stat_rd, exp_stat());
      end
      tot++;
      if (bus.out_data !== 32'h1 || bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_head got=%h/%b exp=00000001/1", bus.out_data, bus.overflow);
      end
      drain(DEP);
      tot++;
      if (bus.stat_rd[15:0] !== 16'h0005 || last_out !== 32'h8) begin
         bad++;
         $display("FAIL ovf_drain got=%h/%h exp=0005/00000008", bus.stat_rd[15:0], last_out);
      end
      store(STAT, 32'h0);
      tot++;
      if (bus.stat_rd !== 32'h0000_0001) begin
         bad++;
         $display("FAIL ovf_clear got=%h exp=%h", bus.stat_rd, 32'h1);
      end
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < DEP; i++) store(TX, 32'h100 + 32'(i));
      bus.out_ready = 1'b1;
      store(TX, 32'h77);
      bus.out_ready = 1'b0;
      tot++;
      if (bus.stat_rd !== 32'h0000_0802) begin
         bad++;
         $display("FAIL full_pp_stat got=%h exp=%h", bus.stat_rd, 32'h802);
      end
      drain(DEP);
      tot++;
      if (last_out !== 32'h77 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_pp_last got=%h exp=00000077", last_out);
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         store(TX, 32'hC000 + 32'(i));
         tot++;
         if (bus.stat_rd[15:8] > 8'd1 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got=%h exp<=01", bus.stat_rd[15:8]);
         end
      end
      cycle();
      bus.out_ready = 1'b0;
      tot++;
      if (last_out !== 32'hC013 || bus.stat_rd !== 32'h1) begin
         bad++;
         $display("FAIL b2b_end got=%h/%h exp=0000c013/00000001", last_out, bus.stat_rd);
      end
   endtask

   task automatic test_addr_decode();
      store(32'h0000_1000, 32'h11);
      store(TX + 32'h1, 32'h22);
      store(32'h0001_FFF0, 32'h33);
      tot++;
      if (bus.stat_rd !== 32'h1) begin
         bad++;
         $display("FAIL other_addr got=%h exp=%h", bus.stat_rd, 32'h1);
      end
      bus.dataadr = STAT;
      #1;
      tot++;
      if (bus.stat_sel !== 1'b1) begin
         bad++;
         $display("FAIL stat_sel_hit got=%b exp=1", bus.stat_sel);
      end
      bus.dataadr = TX;
      #1;
      tot++;
      if (bus.stat_sel !== 1'b0) begin
         bad++;
         $display("FAIL stat_sel_miss got=%b exp=0", bus.stat_sel);
      end
      bus.dataadr = 32'h0;
   endtask

   task automatic test_drop_count();
      for (int i = 0; i < DEP + 3; i++) store(TX, 32'hD0 + 32'(i));
      tot++;
      if (bus.stat_rd !== exp_stat()) begin
         bad++;
         $display("FAIL drop_stat got=%h exp=%h", bus.stat_rd, exp_stat());
      end
`ifdef MMIO_DROP_CNT_EN
      tot++;
      if (bus.stat_rd[31:16] !== 16'd3) begin
         bad++;
         $display("FAIL drop_cnt got=%h exp=0003", bus.stat_rd[31:16]);
      end
`endif
      store(STAT, 32'h0);
      tot++;
      if (bus.stat_rd !== 32'h0000_0802) begin
         bad++;
         $display("FAIL drop_clear got=%h exp=%h", bus.stat_rd, 32'h802);
      end
      drain(DEP);
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 4; i++) store(TX, 32'hE0 + 32'(i));
      drain(1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      tot++;
      if (bus.out_valid !== 1'b0 || bus.stat_rd !== 32'h1) begin
         bad++;
         $display("FAIL async_reset got=%b/%h exp=0/00000001", bus.out_valid, bus.stat_rd);
      end
      sb.delete();
      ovf_m = 1'b0;
      drop_m = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      store(TX, 32'hF00D);
      drain(1);
      tot++;
      if (last_out !== 32'hF00D) begin
         bad++;
         $display("FAIL post_reset got=%h exp=0000f00d", last_out);
      end
   endtask

   initial begin
      bus.memwrite = 1'b0;
      bus.dataadr = 32'h0;
      bus.writedata = 32'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_pushpop();
      test_back_to_back();
      test_addr_decode();
      test_drop_count();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
